// File: rtl/tennis_node.sv
// tennis_node: one end of a ping-pong link built on an external PPM Encoder/Decoder pair.
//
// The initiator serves first. It owns the LISTEN timeout and the bounded retry and it
// raises a sticky link_fail flag when the retries run out. The responder answers every
// good word with its own LFSR word. When a reply is lost, the responder sees the same
// word again and resends its previous reply.
//
// Optional feature: define TENNIS_STATS_EN to build the ok/err/timeout counters.
// Without it the three count ports read constant 0.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   en                      level; the node leaves IDLE while high
//   start_ENC, data_ENC     one-cycle start pulse and held word to the Encoder
//   avail_ENC               Encoder idle/ready
//   data_DEC, avail_DEC,
//   error_DEC               received word, word-present flag and corrupt flag from the Decoder
//   read_DEC                one-cycle consume pulse to the Decoder
//   expected_data_received  one-cycle pulse on each good exchange
//   link_fail               sticky; set when the retries are exhausted
//   state_o                 current FSM state code
//   ok_count, err_count,
//   to_count                saturating statistics counters
module tennis_node #(
   parameter int               WIDTH     = 8,
   parameter int               INITIATOR = 0,
   parameter int               TIMEOUT   = 1540,
   parameter int               MAX_RETRY = 3,
   parameter logic [WIDTH-1:0] SEED_TX   = 8'h42,
   parameter logic [WIDTH-1:0] SEED_RX   = 8'h8F,
   parameter logic [WIDTH-1:0] TAPS      = 8'hB8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             start_ENC,
   output logic [WIDTH-1:0] data_ENC,
   input  logic             avail_ENC,
   input  logic [WIDTH-1:0] data_DEC,
   input  logic             avail_DEC,
   input  logic             error_DEC,
   output logic             read_DEC,
   output logic             expected_data_received,
   output logic             link_fail,
   output logic [2:0]       state_o,
   output logic [15:0]      ok_count,
   output logic [15:0]      err_count,
   output logic [15:0]      to_count
);

   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] TX_INIT  = (SEED_TX == '0) ? ONE_W : SEED_TX;
   localparam logic [WIDTH-1:0] RX_INIT  = (SEED_RX == '0) ? ONE_W : SEED_RX;
   localparam int               TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
   localparam int               RW       = $clog2(MAX_RETRY + 2);
   localparam logic [RW-1:0]    R_MAX    = RW'(MAX_RETRY);
   localparam bit               IS_INIT  = (INITIATOR != 0);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND    = 3'd1,
      ST_TX_BUSY = 3'd2,
      ST_LISTEN  = 3'd3,
      ST_CHECK   = 3'd4,
      ST_FAIL    = 3'd5
   } state_t;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & TAPS)};
   endfunction

   state_t           state_r, state_s;
   logic [WIDTH-1:0] tx_lfsr_r, tx_lfsr_s, exp_lfsr_r, exp_lfsr_s;
   logic [WIDTH-1:0] prev_tx_r, prev_tx_s, prev_exp_r, prev_exp_s;
   logic             prev_valid_r, prev_valid_s;
   logic [RW-1:0]    retry_r, retry_s;
   logic [TW-1:0]    timer_r, timer_s;
   logic             seen_low_r, seen_low_s;
   logic [WIDTH-1:0] rx_word_r, rx_word_s, resp_word_r, resp_word_s;
   logic             rx_err_r, rx_err_s;
   logic             start_r, start_s, read_r, read_s, edr_r, edr_s;
   logic [WIDTH-1:0] data_enc_r, data_enc_s;
   logic             link_fail_r, link_fail_s;
   logic             ok_inc_s, err_inc_s, to_inc_s, retry_path_s;

   // Next-state and next-output decode for the exchange FSM
   always_comb begin
      state_s      = state_r;
      tx_lfsr_s    = tx_lfsr_r;
      exp_lfsr_s   = exp_lfsr_r;
      prev_tx_s    = prev_tx_r;
      prev_exp_s   = prev_exp_r;
      prev_valid_s = prev_valid_r;
      retry_s      = retry_r;
      timer_s      = timer_r;
      seen_low_s   = seen_low_r;
      rx_word_s    = rx_word_r;
      rx_err_s     = rx_err_r;
      resp_word_s  = resp_word_r;
      data_enc_s   = data_enc_r;
      link_fail_s  = link_fail_r;
      start_s      = 1'b0;
      read_s       = 1'b0;
      edr_s        = 1'b0;
      ok_inc_s     = 1'b0;
      err_inc_s    = 1'b0;
      to_inc_s     = 1'b0;
      retry_path_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            timer_s = '0;
            if (en) begin
               state_s = IS_INIT ? ST_SEND : ST_LISTEN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (avail_ENC) begin
               start_s    = 1'b1;
               data_enc_s = IS_INIT ? tx_lfsr_r : resp_word_r;
               seen_low_s = 1'b0;
               state_s    = ST_TX_BUSY;
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_TX_BUSY: begin
            // A high avail_ENC only counts as completion after it has been seen low
            if (!avail_ENC) begin
               seen_low_s = 1'b1;
            end else if (seen_low_r) begin
               timer_s = '0;
               state_s = (IS_INIT || en) ? ST_LISTEN : ST_IDLE;
            end else begin
               state_s = ST_TX_BUSY;
            end
         end
         ST_LISTEN: begin
            if (avail_DEC) begin
               read_s    = 1'b1;
               rx_word_s = data_DEC;
               rx_err_s  = error_DEC;
               state_s   = ST_CHECK;
            end else if (IS_INIT && (timer_r == T_LAST)) begin
               to_inc_s     = 1'b1;
               retry_path_s = 1'b1;
            end else if (IS_INIT) begin
               timer_s = timer_r + TW'(1'b1);
            end else begin
               state_s = ST_LISTEN;
            end
         end
         ST_CHECK: begin
            if (IS_INIT) begin
               if (!rx_err_r && (rx_word_r == exp_lfsr_r)) begin
                  edr_s      = 1'b1;
                  ok_inc_s   = 1'b1;
                  retry_s    = '0;
                  tx_lfsr_s  = lfsr_step(tx_lfsr_r);
                  exp_lfsr_s = lfsr_step(exp_lfsr_r);
                  state_s    = en ? ST_SEND : ST_IDLE;
               end else begin
                  err_inc_s    = 1'b1;
                  retry_path_s = 1'b1;
               end
            end else begin
               if (rx_err_r) begin
                  err_inc_s = 1'b1;
                  state_s   = en ? ST_LISTEN : ST_IDLE;
               end else if (rx_word_r == exp_lfsr_r) begin
                  edr_s        = 1'b1;
                  ok_inc_s     = 1'b1;
                  prev_tx_s    = tx_lfsr_r;
                  prev_exp_s   = exp_lfsr_r;
                  prev_valid_s = 1'b1;
                  resp_word_s  = tx_lfsr_r;
                  tx_lfsr_s    = lfsr_step(tx_lfsr_r);
                  exp_lfsr_s   = lfsr_step(exp_lfsr_r);
                  state_s      = ST_SEND;
               end else if (prev_valid_r && (rx_word_r == prev_exp_r)) begin
                  // The peer missed our reply and repeated its word; answer it again
                  resp_word_s = prev_tx_r;
                  state_s     = ST_SEND;
               end else begin
                  err_inc_s = 1'b1;
                  state_s   = en ? ST_LISTEN : ST_IDLE;
               end
            end
         end
         ST_FAIL: begin
            link_fail_s = 1'b1;
            state_s     = ST_FAIL;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Shared retry path for timeouts and bad replies; the same word is resent
      if (retry_path_s) begin
         retry_s = retry_r + RW'(1'b1);
         if (retry_r >= R_MAX) begin
            link_fail_s = 1'b1;
            state_s     = ST_FAIL;
         end else begin
            state_s = en ? ST_SEND : ST_IDLE;
         end
      end else begin
         retry_s = retry_s;
      end
   end

   // State, datapath and registered-output update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         tx_lfsr_r    <= TX_INIT;
         exp_lfsr_r   <= RX_INIT;
         prev_tx_r    <= '0;
         prev_exp_r   <= '0;
         prev_valid_r <= 1'b0;
         retry_r      <= '0;
         timer_r      <= '0;
         seen_low_r   <= 1'b0;
         rx_word_r    <= '0;
         rx_err_r     <= 1'b0;
         resp_word_r  <= '0;
         data_enc_r   <= '0;
         link_fail_r  <= 1'b0;
         start_r      <= 1'b0;
         read_r       <= 1'b0;
         edr_r        <= 1'b0;
      end else begin
         state_r      <= state_s;
         tx_lfsr_r    <= tx_lfsr_s;
         exp_lfsr_r   <= exp_lfsr_s;
         prev_tx_r    <= prev_tx_s;
         prev_exp_r   <= prev_exp_s;
         prev_valid_r <= prev_valid_s;
         retry_r      <= retry_s;
         timer_r      <= timer_s;
         seen_low_r   <= seen_low_s;
         rx_word_r    <= rx_word_s;
         rx_err_r     <= rx_err_s;
         resp_word_r  <= resp_word_s;
         data_enc_r   <= data_enc_s;
         link_fail_r  <= link_fail_s;
         start_r      <= start_s;
         read_r       <= read_s;
         edr_r        <= edr_s;
      end
   end

   assign start_ENC              = start_r;
   assign data_ENC               = data_enc_r;
   assign read_DEC               = read_r;
   assign expected_data_received = edr_r;
   assign link_fail              = link_fail_r;
   assign state_o                = state_r;

`ifdef TENNIS_STATS_EN
   logic [15:0] ok_r, err_r, to_r;

   // Saturating statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_r  <= 16'h0000;
         err_r <= 16'h0000;
         to_r  <= 16'h0000;
      end else begin
         if (ok_inc_s && (ok_r != 16'hFFFF)) begin
            ok_r <= ok_r + 16'd1;
         end
         if (err_inc_s && (err_r != 16'hFFFF)) begin
            err_r <= err_r + 16'd1;
         end
         if (to_inc_s && (to_r != 16'hFFFF)) begin
            to_r <= to_r + 16'd1;
         end
      end
   end

   assign ok_count  = ok_r;
   assign err_count = err_r;
   assign to_count  = to_r;
`else
   logic unused_stats_s;
   assign unused_stats_s = ^{ok_inc_s, err_inc_s, to_inc_s};
   assign ok_count  = 16'h0000;
   assign err_count = 16'h0000;
   assign to_count  = 16'h0000;
`endif

endmodule

// File: doc/tennis_node.md
Name: tennis_node

Overview:
- Parametrised ping-pong ("tennis") link node: one instance drives one PPM Encoder and consumes one PPM Decoder, closing a two-node loopback exchange.
- Generalises the fixed player1/player2 pair into a single block with a role parameter, built-in LFSR word generators, bounded retransmission, responder-side duplicate detection and a sticky link-fail flag.
- Sits between the external PPM Encoder/Decoder pair and top-level status logic.

Parameters:
- WIDTH, 8, packet width in bits; must equal the Encoder/Decoder N_PKT.
- INITIATOR, 0, 1 = serves first and owns the timeout/retry; 0 = responder.
- TIMEOUT, 1540, LISTEN cycles before the initiator declares a timeout; must be >= 1.
- MAX_RETRY, 3, consecutive failed attempts allowed before FAIL.
- SEED_TX, 8'h42, transmit LFSR seed; 0 is replaced by 1.
- SEED_RX, 8'h8F, expected-word LFSR seed; 0 is replaced by 1; must equal the peer's SEED_TX.
- TAPS, 8'hB8, feedback mask.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; node leaves IDLE while high
- start_ENC  out  1  one-cycle start pulse to Encoder
- data_ENC  out  WIDTH  word to Encoder; held stable from start until avail_ENC returns high
- avail_ENC  in  1  Encoder idle/ready
- data_DEC  in  WIDTH  received word; valid while avail_DEC=1
- avail_DEC  in  1  Decoder holds a word
- error_DEC  in  1  Decoder word is corrupt; qualified by avail_DEC
- read_DEC  out  1  one-cycle consume pulse to Decoder
- expected_data_received  out  1  one-cycle pulse on each good exchange
- link_fail  out  1  sticky; set on retry exhaustion
- state_o  out  3  current FSM state code
- ok_count  out  16  good exchanges
- err_count  out  16  decoder errors plus mismatches
- to_count  out  16  timeouts

Behaviour:
- Reset (asynchronous):
  - state=IDLE; every output 0.
  - tx_lfsr=SEED_TX; exp_lfsr=SEED_RX; prev_tx=0; prev_exp=0; prev_valid=0; retry=0; timer=0.
- LFSR step: next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- State codes: IDLE=0, SEND=1, TX_BUSY=2, LISTEN=3, CHECK=4, FAIL=5.
- IDLE: on en=1, initiator goes to SEND; responder goes to LISTEN.
- SEND:
  - When avail_ENC=1: assert start_ENC for one cycle with data_ENC = the selected word, then go to TX_BUSY.
  - If avail_ENC=0, stay in SEND with no start pulse.
- TX_BUSY:
  - Wait for avail_ENC to fall, then rise again. The fall is required first, so a stale high is not mistaken for completion.
  - Then go to LISTEN with timer=0.
- LISTEN:
  - On avail_DEC=1: pulse read_DEC for one cycle, latch data_DEC and error_DEC, go to CHECK.
  - Initiator only: timer increments each cycle. When timer reaches TIMEOUT-1 with avail_DEC=0, to_count++ and take the retry path.
  - Responder has no timeout.
  - If avail_DEC and the timeout occur in the same cycle, avail_DEC wins.
- CHECK, initiator:
  - Good (no error, word==exp_lfsr): pulse expected_data_received, ok_count++, retry=0, step both LFSRs, go to SEND.
  - Otherwise: err_count++, take the retry path.
  - Retry path: retry++. If retry exceeds MAX_RETRY, set link_fail and go to FAIL. Else go to SEND with the same tx_lfsr word.
- CHECK, responder:
  - Error: err_count++, back to LISTEN.
  - word==exp_lfsr: pulse expected_data_received, ok_count++. Save prev_tx=tx_lfsr, prev_exp=exp_lfsr, prev_valid=1. Send tx_lfsr, step both LFSRs.
  - Else if prev_valid and word==prev_exp (duplicate after a lost reply): resend prev_tx; no LFSR step; err_count unchanged.
  - Otherwise: err_count++, back to LISTEN.
- FAIL: absorbing; link_fail stays 1. Only reset leaves FAIL.
- en=0: allows the current state to complete, then holds in IDLE before the next SEND (initiator) or LISTEN (responder). LFSR and counter state are kept.
- Counters saturate at 16'hFFFF.
- Reset mid-exchange returns to the reset state immediately; the Encoder and Decoder are reset by the same rst_n.

Optional Feature:
- Macro: TENNIS_STATS_EN.
- Defined: ok_count, err_count and to_count behave as above.
- Undefined: the counter registers are not built; the three ports read constant 0. All other behaviour is unchanged.

Test Plan:
- Initiator and responder with matched seeds (SEED_TX/SEED_RX crossed), ideal link, en=1 for 20 exchanges:
  - the first words are 8'h42 and 8'h8F;
  - ok_count=20 on both nodes; err_count=0; link_fail=0;
  - expected_data_received pulses once per exchange.
- Responder never replies, MAX_RETRY=3, TIMEOUT=100:
  - exactly 4 start_ENC pulses, all with data_ENC=8'h42;
  - to_count=4; link_fail=1; state_o=5.
- Reply dropped once after initiator word 2: responder sees the duplicate and resends the identical prev_tx; initiator ok_count continues; responder err_count=0.
- error_DEC=1 on the responder's input: read_DEC pulses, err_count=1, responder stays in LISTEN, no LFSR step.
- avail_ENC held low for 50 cycles in SEND: no start_ENC; start fires the cycle after avail_ENC rises.
- rst_n pulled low in TX_BUSY: all outputs 0 asynchronously; after release the first data_ENC is SEED_TX again.
